// File: rtl/p_dec_pkg.sv
// Shared types and constants for the sequenced 3-to-8 decoder.
package p_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int FIFO_DEPTH      = 2;
    localparam int HOLD_CYCLES_DEF = 4;
    localparam int GAP_CYCLES_DEF  = 1;

    // Decode a 3-bit line index into a one-hot byte.
    function automatic logic [7:0] onehot3(input logic [2:0] code);
        return 8'd1 << code;
    endfunction

endpackage

// File: rtl/p_dec_fifo.sv
// Two-entry, 3-bit synchronous FIFO holding accepted codes until the FSM drives them.
module p_dec_fifo
    import p_dec_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [2:0] din,
    input  logic       pop,
    output logic [2:0] dout,
    output logic       full,
    output logic       empty
);

    logic [2:0] mem_q [FIFO_DEPTH];
    logic [2:0] mem_d [FIFO_DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       do_push, do_pop;

    assign full    = (cnt_q == 2'(FIFO_DEPTH));
    assign empty   = (cnt_q == 2'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; push and pop may coincide.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    // FIFO state registers; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/p_dec_3x8_seq.sv
// Sequenced 3-to-8 decoder: queues encoded line indices and drives each
// decoded line for HOLD_CYCLES, followed by GAP_CYCLES of idle, then IDLE.
module p_dec_3x8_seq
    import p_dec_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] Q,
    input  logic       v,
    output logic       ready,
    output logic [7:0] D,
    output logic       busy,
    output logic       done,
    input  logic       clr_hist,
    output logic [7:0] hist
);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] d_q, d_d;
    logic       done_q, done_d;
    logic [7:0] hist_q, hist_d;

    logic       fifo_full, fifo_empty;
    logic [2:0] fifo_dout;
    logic       push, pop;

    // A code is taken only when offered and there is room for it.
    assign ready = ~fifo_full;
    assign push  = v & ready;
    // The FSM pulls the next code only from IDLE, which enforces the idle
    // cycle between GAP and the following drive.
    assign pop   = (state_q == ST_IDLE) & ~fifo_empty;

    p_dec_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (Q),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM next state, hold/gap counter, decoded output and history.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        done_d  = 1'b0;
        hist_d  = clr_hist ? 8'h00 : hist_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    d_d     = onehot3(fifo_dout);
                    cnt_d   = 8'(HOLD_CYCLES - 1);
                    hist_d  = hist_d | onehot3(fifo_dout);
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 8'd0) begin
                    d_d     = 8'h00;
                    done_d  = 1'b1;
                    cnt_d   = 8'(GAP_CYCLES - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                d_d     = 8'h00;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Registered FSM and outputs; reset drops any active or queued drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            d_q     <= 8'h00;
            done_q  <= 1'b0;
            hist_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            done_q  <= done_d;
            hist_q  <= hist_d;
        end
    end

    assign D    = d_q;
    assign done = done_q;
    assign hist = hist_q;
    assign busy = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_p_dec_3x8_seq.sv
// Scoreboard bench for p_dec_3x8_seq: accepted codes push expected D values,
// a negedge monitor pops them when a drive starts and checks hold/done timing.
module tb_p_dec_3x8_seq;

    localparam int HOLD = 4;
    localparam int GAP  = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] Q;
    logic       v;
    logic       ready;
    logic [7:0] D;
    logic       busy;
    logic       done;
    logic       clr_hist;
    logic [7:0] hist;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_done = 0;

    logic [7:0] exp_q[$];
    int         acc_cyc[$];
    int         load_cyc[$];

    p_dec_3x8_seq #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Q        (Q),
        .v        (v),
        .ready    (ready),
        .D        (D),
        .busy     (busy),
        .done     (done),
        .clr_hist (clr_hist),
        .hist     (hist)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge counter and acceptance capture: expected D value is 1 << Q.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst_n === 1'b1 && v === 1'b1 && ready === 1'b1) begin
                exp_q.push_back(8'd1 << Q);
                acc_cyc.push_back(cyc);
            end
        end
    end

    // Monitor: compares drives against the scoreboard and checks drive shape.
    initial begin
        logic [7:0] prev_d;
        int         hold;
        logic [7:0] e;
        prev_d = 8'h00;
        hold   = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_d = 8'h00;
                hold   = 0;
            end else begin
                chk("onehot", 32'($countones(D) <= 1), 32'd1);
                if (D != 8'h00 && prev_d == 8'h00) begin
                    load_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_drive", {24'h0, D}, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("d_value", {24'h0, D}, {24'h0, e});
                    end
                    hold = 0;
                end else if (D != 8'h00) begin
                    chk("d_stable", {24'h0, D}, {24'h0, prev_d});
                end
                if (D != 8'h00) hold++;
                if (D == 8'h00 && prev_d != 8'h00) begin
                    chk("hold_len", 32'(hold), 32'(HOLD));
                    chk("done_at_end", {31'h0, done}, 32'd1);
                end else if (done === 1'b1) begin
                    chk("stray_done", {31'h0, done}, 32'd0);
                end
                if (done === 1'b1) n_done++;
                prev_d = D;
            end
        end
    end

    // Offer one code, holding v until it is accepted (bounded wait).
    task automatic send(input logic [2:0] code);
        logic acc;
        int   tries;
        Q     = code;
        v     = 1'b1;
        tries = 0;
        do begin
            acc = ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!acc && tries < 50);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        v = 1'b0;
    endtask

    initial begin
        int b;
        int nd;
        int nl;
        rst_n    = 1'b0;
        Q        = 3'd0;
        v        = 1'b0;
        clr_hist = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_D", {24'h0, D}, 32'h00);
        chk("rst_hist", {24'h0, hist}, 32'h00);
        chk("rst_ready", {31'h0, ready}, 32'd1);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single code 5: one-edge latency, hist, back to idle
        send(3'd5);
        repeat (12) @(posedge clk);
        #1;
        chk("single_loads", 32'(load_cyc.size()), 32'd1);
        if (load_cyc.size() >= 1 && acc_cyc.size() >= 1)
            chk("single_latency", 32'(load_cyc[0] - acc_cyc[0]), 32'd1);
        chk("single_hist", {24'h0, hist}, 32'h20);
        chk("single_busy", {31'h0, busy}, 32'd0);
        chk("single_done_cnt", 32'(n_done), 32'd1);

        // Codes 0, 7, 3 back to back: FIFO fills, 6-cycle spacing
        b = load_cyc.size();
        send(3'd0);
        send(3'd7);
        send(3'd3);
        chk("b2b_ready_low", {31'h0, ready}, 32'd0);
        chk("b2b_busy", {31'h0, busy}, 32'd1);
        repeat (25) @(posedge clk);
        #1;
        chk("b2b_loads", 32'(load_cyc.size() - b), 32'd3);
        if (load_cyc.size() >= b + 3) begin
            chk("b2b_space1", 32'(load_cyc[b+1] - load_cyc[b]), 32'(HOLD + GAP + 1));
            chk("b2b_space2", 32'(load_cyc[b+2] - load_cyc[b+1]), 32'(HOLD + GAP + 1));
        end
        chk("b2b_hist", {24'h0, hist}, 32'hA9);
        chk("b2b_busy_end", {31'h0, busy}, 32'd0);

        // v = 0 with Q = 6: nothing happens
        nd = n_done;
        nl = load_cyc.size();
        Q  = 3'd6;
        v  = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_D", {24'h0, D}, 32'h00);
        chk("idle_busy", {31'h0, busy}, 32'd0);
        chk("idle_done_cnt", 32'(n_done), 32'(nd));
        chk("idle_loads", 32'(load_cyc.size()), 32'(nl));

        // Reset during the 2nd DRIVE cycle of code 2 with code 4 queued
        send(3'd2);
        send(3'd4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_D", {24'h0, D}, 32'h00);
        chk("mid_rst_done", {31'h0, done}, 32'd0);
        chk("mid_rst_busy", {31'h0, busy}, 32'd0);
        chk("mid_rst_ready", {31'h0, ready}, 32'd1);
        chk("mid_rst_hist", {24'h0, hist}, 32'h00);
        nd = n_done;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nl = load_cyc.size();
        repeat (15) @(posedge clk);
        #1;
        chk("post_rst_loads", 32'(load_cyc.size()), 32'(nl));
        chk("post_rst_done", 32'(n_done), 32'(nd));

        // clr_hist on the load edge of code 1 while hist = 0x20
        send(3'd5);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_clr_hist", {24'h0, hist}, 32'h20);
        send(3'd1);
        clr_hist = 1'b1;
        @(posedge clk);
        #1;
        clr_hist = 1'b0;
        chk("clr_set_wins", {24'h0, hist}, 32'h02);
        repeat (10) @(posedge clk);
        #1;
        chk("final_busy", {31'h0, busy}, 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
